// File: rtl/conv_controller.sv
// Sequencing FSM for the convolution datapath: issues every strobe the
// datapath consumes and uses its counter carry-outs as loop terminators.
module conv_controller #(
   parameter int N       = 4,
   parameter int NO_ROWS = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         write_filter_buff_counter_cout,
   input  logic         read_filter_buff_counter_cout,
   input  logic         write_main_buff_counter_cout,
   input  logic         read_main_buff_counter_cout,
   output logic         load_x,
   output logic         sel_x,
   output logic         load_y,
   output logic         sel_y,
   output logic         load_z,
   output logic         sel_z,
   output logic         mem_addr_sel,
   output logic [N-1:0] write_filter_buff_en,
   output logic         write_filter_buff_counter_en,
   output logic         write_main_buff_counter_en,
   output logic         read_main_buff_counter_en,
   output logic         read_filter_buff_counter_en,
   output logic         write_main_buff_en,
   output logic         shift_main_buff_en,
   output logic         write_window_buff_en,
   output logic         reset_mac,
   output logic         partial_res_en,
   output logic         shift_reg_en,
   output logic         finalize_shift_reg,
   output logic         mem_write_en,
   output logic         done,
   output logic         busy
);

   localparam int PE_W = (N > 1) ? $clog2(N) : 1;
   localparam int RL_W = (NO_ROWS > 0) ? $clog2(NO_ROWS + 1) : 1;
   localparam logic [PE_W-1:0] PE_LAST = PE_W'(N - 1);

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      LOAD_FILTER,
      LOAD_MAIN,
      LOAD_WIN,
      MAC,
      STORE,
      NEXT_ROW,
      FINAL,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [PE_W-1:0]   pe_idx;
   logic [RL_W-1:0]   rows_left;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pe_idx    <= '0;
         rows_left <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            INIT: begin
               pe_idx    <= '0;
               rows_left <= RL_W'(NO_ROWS);
            end
            LOAD_FILTER: begin
               if (write_filter_buff_counter_cout && (pe_idx != PE_LAST))
                  pe_idx <= pe_idx + PE_W'(1);
            end
            NEXT_ROW: rows_left <= rows_left - RL_W'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt                    = state;
      load_x                       = 1'b0;
      sel_x                        = 1'b0;
      load_y                       = 1'b0;
      sel_y                        = 1'b0;
      load_z                       = 1'b0;
      sel_z                        = 1'b0;
      mem_addr_sel                 = 1'b0;
      write_filter_buff_en         = '0;
      write_filter_buff_counter_en = 1'b0;
      write_main_buff_counter_en   = 1'b0;
      read_main_buff_counter_en    = 1'b0;
      read_filter_buff_counter_en  = 1'b0;
      write_main_buff_en           = 1'b0;
      shift_main_buff_en           = 1'b0;
      write_window_buff_en         = 1'b0;
      reset_mac                    = 1'b0;
      partial_res_en               = 1'b0;
      shift_reg_en                 = 1'b0;
      finalize_shift_reg           = 1'b0;
      mem_write_en                 = 1'b0;
      done                         = 1'b0;
      busy                         = (state != IDLE);

      case (state)
         IDLE: begin
            if (start) state_nxt = INIT;
         end
         INIT: begin
            sel_x     = 1'b1;
            sel_y     = 1'b1;
            sel_z     = 1'b1;
            load_x    = 1'b1;
            load_y    = 1'b1;
            load_z    = 1'b1;
            state_nxt = LOAD_FILTER;
         end
         LOAD_FILTER: begin
            mem_addr_sel                 = 1'b1;
            load_y                       = 1'b1;
            write_filter_buff_en         = N'(1) << pe_idx;
            write_filter_buff_counter_en = 1'b1;
            if (write_filter_buff_counter_cout && (pe_idx == PE_LAST))
               state_nxt = LOAD_MAIN;
         end
         LOAD_MAIN: begin
            load_x                     = 1'b1;
            write_main_buff_en         = 1'b1;
            write_main_buff_counter_en = 1'b1;
            if (write_main_buff_counter_cout) state_nxt = LOAD_WIN;
         end
         LOAD_WIN: begin
            write_window_buff_en = 1'b1;
            reset_mac            = 1'b1;
            state_nxt            = MAC;
         end
         MAC: begin
            // the cout cycle still accumulates; the exit happens after it
            read_filter_buff_counter_en = 1'b1;
            partial_res_en              = 1'b1;
            if (read_filter_buff_counter_cout) state_nxt = STORE;
         end
         STORE: begin
            shift_reg_en              = 1'b1;
            read_main_buff_counter_en = 1'b1;
            if (!read_main_buff_counter_cout) state_nxt = LOAD_WIN;
            else if (rows_left != '0)         state_nxt = NEXT_ROW;
            else                              state_nxt = FINAL;
         end
         NEXT_ROW: begin
            shift_main_buff_en = 1'b1;
            write_main_buff_en = 1'b1;
            load_x             = 1'b1;
            state_nxt          = LOAD_WIN;
         end
         FINAL: begin
            finalize_shift_reg = 1'b1;
            mem_write_en       = 1'b1;
            load_z             = 1'b1;
            state_nxt          = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_conv_controller.sv
// Bench for conv_controller: two instances (NO_ROWS=0 and NO_ROWS=2) driven
// by behavioural datapath counters; done timing is tracked by a queue.
module tb_conv_controller;

   typedef struct packed {
      logic       load_x;
      logic       sel_x;
      logic       load_y;
      logic       sel_y;
      logic       load_z;
      logic       sel_z;
      logic       mem_addr_sel;
      logic [3:0] wfbe;
      logic       wfc_en;
      logic       wmc_en;
      logic       rmc_en;
      logic       rfc_en;
      logic       wmb_en;
      logic       smb_en;
      logic       wwb_en;
      logic       reset_mac;
      logic       partial_res_en;
      logic       shift_reg_en;
      logic       finalize_shift_reg;
      logic       mem_write_en;
      logic       done;
      logic       busy;
   } outs_t;

   typedef struct {
      int inst;
      int mode;      // 0 pulse, 1 toggle while busy, 2 premature cout, 3 hold
      int exp_done;
      int n_runs;
      int exp_sr;
      int exp_sm;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] start_v = 2'b00;
   logic [1:0] force_rfc = 2'b00;
   int         checks = 0;
   int         failures = 0;
   int         exp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic       load_x, sel_x, load_y, sel_y, load_z, sel_z, mem_addr_sel;
      logic [3:0] wfbe;
      logic       wfc_en, wmc_en, rmc_en, rfc_en;
      logic       wmb_en, smb_en, wwb_en;
      logic       reset_mac, partial_res_en, shift_reg_en, finalize_shift_reg, mem_write_en;
      logic       done, busy;
      logic [1:0] wf_cnt, wm_cnt;
      logic [3:0] rf_cnt, rm_cnt;
      logic       wf_cout, rf_cout, wm_cout, rm_cout;
      outs_t      s;

      conv_controller #(.N(4), .NO_ROWS(2 * g)) dut (
         .clk                            (clk),
         .rst                            (rst),
         .start                          (start_v[g]),
         .write_filter_buff_counter_cout (wf_cout),
         .read_filter_buff_counter_cout  (rf_cout),
         .write_main_buff_counter_cout   (wm_cout),
         .read_main_buff_counter_cout    (rm_cout),
         .load_x                         (load_x),
         .sel_x                          (sel_x),
         .load_y                         (load_y),
         .sel_y                          (sel_y),
         .load_z                         (load_z),
         .sel_z                          (sel_z),
         .mem_addr_sel                   (mem_addr_sel),
         .write_filter_buff_en           (wfbe),
         .write_filter_buff_counter_en   (wfc_en),
         .write_main_buff_counter_en     (wmc_en),
         .read_main_buff_counter_en      (rmc_en),
         .read_filter_buff_counter_en    (rfc_en),
         .write_main_buff_en             (wmb_en),
         .shift_main_buff_en             (smb_en),
         .write_window_buff_en           (wwb_en),
         .reset_mac                      (reset_mac),
         .partial_res_en                 (partial_res_en),
         .shift_reg_en                   (shift_reg_en),
         .finalize_shift_reg             (finalize_shift_reg),
         .mem_write_en                   (mem_write_en),
         .done                           (done),
         .busy                           (busy)
      );

      assign wf_cout = (wf_cnt == 2'd3);
      assign wm_cout = (wm_cnt == 2'd3);
      assign rf_cout = (rf_cnt == 4'd15) || force_rfc[g];
      assign rm_cout = (rm_cnt == 4'd12);

      always_ff @(posedge clk) begin
         if (rst) begin
            wf_cnt <= '0;
            wm_cnt <= '0;
            rf_cnt <= '0;
            rm_cnt <= '0;
         end else begin
            if (wfc_en) wf_cnt <= wf_cnt + 2'd1;
            if (wmc_en) wm_cnt <= wm_cnt + 2'd1;
            if (rfc_en) rf_cnt <= rf_cnt + 4'd1;
            if (rmc_en) rm_cnt <= (rm_cnt == 4'd12) ? 4'd0 : rm_cnt + 4'd1;
         end
      end

      assign s = {load_x, sel_x, load_y, sel_y, load_z, sel_z, mem_addr_sel, wfbe,
                  wfc_en, wmc_en, rmc_en, rfc_en, wmb_en, smb_en, wwb_en,
                  reset_mac, partial_res_en, shift_reg_en, finalize_shift_reg,
                  mem_write_en, done, busy};
   end

   function automatic outs_t get(input int inst);
      return (inst == 0) ? g_dut[0].s : g_dut[1].s;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input vec_t v);
      int    k = 0, dones = 0, lk, budget;
      int    sr = 0, sm = 0, fin = 0, mw = 0, lz = 0, lm = 0, wf_err = 0;
      logic [3:0] wf_exp;
      outs_t s;
      budget = v.exp_done + 258 * (v.n_runs - 1) + 20;
      for (int r = 0; r < v.n_runs; r++) exp_q.push_back(v.exp_done + 258 * r);
      start_v[v.inst] = 1'b1;
      while (dones < v.n_runs && k < budget) begin
         tick();
         k++;
         s = get(v.inst);
         lk = k - 258 * dones;
         if (k == 1) check("busy_rise", int'(s.busy), 1);
         wf_exp = (lk >= 2 && lk <= 17) ? (4'b0001 << ((lk - 2) / 4)) : 4'b0000;
         if (s.wfbe !== wf_exp) wf_err++;
         sr  += int'(s.shift_reg_en);
         sm  += int'(s.smb_en);
         fin += int'(s.finalize_shift_reg);
         mw  += int'(s.mem_write_en);
         lz  += int'(s.load_z && !s.sel_z);
         lm  += int'(s.wmc_en);
         if (s.done) begin
            dones++;
            check("busy_in_done", int'(s.busy), 1);
            if (exp_q.size() == 0) check("unexpected_done", k, -1);
            else check("done_cycle", k, exp_q.pop_front());
         end
         if (dones >= v.n_runs) start_v[v.inst] = 1'b0;
         else case (v.mode)
            1:       start_v[v.inst] = ~start_v[v.inst];
            3:       start_v[v.inst] = 1'b1;
            default: start_v[v.inst] = 1'b0;
         endcase
         force_rfc[v.inst] = (v.mode == 2) && (k >= 18) && (k <= 21);
      end
      force_rfc = 2'b00;
      start_v   = 2'b00;
      if (dones < v.n_runs) check("done_timeout", dones, v.n_runs);
      while (exp_q.size() != 0) void'(exp_q.pop_front());
      tick();
      s = get(v.inst);
      check("done_one_cycle", int'(s.done), 0);
      check("busy_after_done", int'(s.busy), 0);
      check("wfbe_seq_errors", wf_err, 0);
      check("shift_reg_pulses", sr, v.exp_sr * v.n_runs);
      check("shift_main_pulses", sm, v.exp_sm * v.n_runs);
      check("finalize_pulses", fin, v.n_runs);
      check("mem_write_pulses", mw, v.n_runs);
      check("load_z_inc_pulses", lz, v.n_runs);
      check("load_main_len", lm, 4 * v.n_runs);
      repeat (3) tick();
      check("idle_busy", int'(get(v.inst).busy), 0);
   endtask

   vec_t tbl[5];

   initial begin
      outs_t s;
      tbl[0] = '{inst: 0, mode: 0, exp_done: 257, n_runs: 1, exp_sr: 13, exp_sm: 0};
      tbl[1] = '{inst: 1, mode: 0, exp_done: 727, n_runs: 1, exp_sr: 13, exp_sm: 2};
      tbl[2] = '{inst: 0, mode: 1, exp_done: 257, n_runs: 1, exp_sr: 13, exp_sm: 0};
      tbl[3] = '{inst: 0, mode: 3, exp_done: 257, n_runs: 2, exp_sr: 13, exp_sm: 0};
      tbl[4] = '{inst: 0, mode: 2, exp_done: 257, n_runs: 1, exp_sr: 13, exp_sm: 0};
      tbl[1].exp_sr = 39;

      repeat (2) tick();
      check("reset_outs_inst0", int'(get(0) != '0), 0);
      check("reset_outs_inst1", int'(get(1) != '0), 0);
      rst = 1'b0;
      tick();

      // abort mid-MAC with a two-cycle reset
      start_v[0] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         start_v[0] = 1'b0;
      end
      check("mid_mac_partial_res", int'(get(0).partial_res_en), 1);
      rst = 1'b1;
      tick();
      s = get(0);
      check("abort_outs_zero", int'(s != '0), 0);
      check("abort_busy", int'(s.busy), 0);
      tick();
      check("abort_hold_zero", int'(get(0) != '0), 0);
      rst = 1'b0;
      tick();
      check("post_abort_idle", int'(get(0).busy), 0);

      for (int i = 0; i < 5; i++) run(tbl[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
